// File: rtl/priority_encoder_pkg.sv
// Shared constants for the priority encoder: default request width,
// encoded index width derivation and output reset values.
package priority_encoder_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  // Index width for a given request width; a single request still needs one bit.
  function automatic int unsigned enc_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DEF_OUT_W = enc_width(DEF_WIDTH);

  localparam int unsigned RST_Y = 0;
  localparam logic        RST_V = 1'b0;
  localparam logic        RST_M = 1'b0;

endpackage

// File: rtl/pe_comb_core.sv
// Purely combinational masked priority encoder with valid and multi-hit flags.
// No clock or reset, so it can be reused standalone.
module pe_comb_core
  import priority_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OUT_W = enc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] mask,
  output logic [OUT_W-1:0] idx_c,
  output logic             valid_c,
  output logic             multi_c
);

  logic [WIDTH-1:0] eff;

  assign eff = req & ~mask;

  // MSB-first scan: once the winner is found, lower bits only feed the multi-hit flag.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    multi_c = 1'b0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (eff[k]) begin
        if (valid_c) begin
          multi_c = 1'b1;
        end else begin
          idx_c   = OUT_W'(k);
          valid_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder8to3.sv
// Registered masked priority encoder: captures the encoded result when en=1,
// holds it otherwise, and clears asynchronously on rst_n.
module priority_encoder8to3
  import priority_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OUT_W = enc_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] mask,
  output logic [OUT_W-1:0] Y,
  output logic             V,
  output logic             M
);

  logic [OUT_W-1:0] y_c;
  logic             v_c;
  logic             m_c;

  pe_comb_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .req     (I),
    .mask    (mask),
    .idx_c   (y_c),
    .valid_c (v_c),
    .multi_c (m_c)
  );

  // All three outputs load together from one sampled request vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= OUT_W'(RST_Y);
      V <= RST_V;
      M <= RST_M;
    end else if (en) begin
      Y <= y_c;
      V <= v_c;
      M <= m_c;
    end
  end

endmodule

// File: tb/tb_priority_encoder8to3.sv
// Self-checking bench for priority_encoder8to3: directed cases with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_priority_encoder8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] I;
  logic [7:0] mask;
  logic [2:0] Y;
  logic       V;
  logic       M;

  int n_checks = 0;
  int n_errors = 0;

  priority_encoder8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .I     (I),
    .mask  (mask),
    .Y     (Y),
    .V     (V),
    .M     (M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: highest set bit via logarithm, valid/multi via population count.
  function automatic logic [2:0] f_y(input logic [7:0] r);
    if (r == 8'h00) return 3'd0;
    return 3'($clog2(int'(r) + 1) - 1);
  endfunction

  function automatic logic f_v(input logic [7:0] r);
    return $countones(r) >= 1;
  endfunction

  function automatic logic f_m(input logic [7:0] r);
    return $countones(r) >= 2;
  endfunction

  logic [2:0] exp_y;
  logic       exp_v;
  logic       exp_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_y <= 3'd0;
      exp_v <= 1'b0;
      exp_m <= 1'b0;
    end else if (en) begin
      exp_y <= f_y(I & ~mask);
      exp_v <= f_v(I & ~mask);
      exp_m <= f_m(I & ~mask);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [2:0] ey, input logic ev, input logic em);
    chk({nm, ".Y"}, 32'(Y), 32'(ey));
    chk({nm, ".V"}, 32'(V), 32'(ev));
    chk({nm, ".M"}, 32'(M), 32'(em));
  endtask

  // Drive inputs just after a falling edge, then advance to the next falling edge.
  task automatic apply(input logic [7:0] i_v, input logic [7:0] m_v, input logic e_v);
    I    = i_v;
    mask = m_v;
    en   = e_v;
    @(negedge clk);
  endtask

  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model.Y", 32'(Y), 32'(exp_y));
      chk("model.V", 32'(V), 32'(exp_v));
      chk("model.M", 32'(M), 32'(exp_m));
    end
  end

  logic [7:0] sweep_i [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] sweep_y [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       sweep_v [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // Pin the model against hand-computed examples.
    chk("pin.y01", 32'(f_y(8'h01)), 32'd0);
    chk("pin.y80", 32'(f_y(8'h80)), 32'd7);
    chk("pin.y24", 32'(f_y(8'h24)), 32'd5);
    chk("pin.m03", 32'(f_m(8'h03)), 32'd1);
    chk("pin.m10", 32'(f_m(8'h10)), 32'd0);
    chk("pin.v00", 32'(f_v(8'h00)), 32'd0);

    rst_n = 1'b0;
    I     = 8'hFF;
    mask  = 8'h00;
    en    = 1'b1;
    #1;
    lit("rst_imm", 3'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      lit("rst_hold", 3'd0, 1'b0, 1'b0);
    end
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    lit("rst_release", 3'd7, 1'b1, 1'b1);

    for (int k = 0; k < 9; k++) begin
      apply(sweep_i[k], 8'h00, 1'b1);
      lit($sformatf("sweep%0d", k), sweep_y[k], sweep_v[k], 1'b0);
    end

    apply(8'hFF, 8'h00, 1'b1); lit("prio_ff", 3'd7, 1'b1, 1'b1);
    apply(8'h24, 8'h00, 1'b1); lit("prio_24", 3'd5, 1'b1, 1'b1);
    apply(8'h03, 8'h00, 1'b1); lit("prio_03", 3'd1, 1'b1, 1'b1);

    apply(8'hFF, 8'hF0, 1'b1); lit("mask_f0", 3'd3, 1'b1, 1'b1);
    apply(8'h80, 8'h80, 1'b1); lit("mask_80", 3'd0, 1'b0, 1'b0);

    apply(8'h10, 8'h00, 1'b1); lit("hold_cap", 3'd4, 1'b1, 1'b0);
    repeat (3) begin
      apply(8'h01, 8'h00, 1'b0);
      lit("hold", 3'd4, 1'b1, 1'b0);
    end
    apply(8'h01, 8'h00, 1'b1); lit("hold_rel", 3'd0, 1'b1, 1'b0);

    apply(8'h40, 8'h00, 1'b1); lit("async_pre", 3'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    lit("async_held", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      apply(8'($urandom),
            ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    apply(8'h00, 8'h00, 1'b1);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
